// File: rtl/ones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ones_pkg
// Description : Shared types and constants for the ones-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package ones_pkg;

    // Default word width of the generator
    localparam int c_DEFAULT_WIDTH = 8;

    // Width of a ones count for the default word width
    localparam int c_KW = $clog2(c_DEFAULT_WIDTH + 1);

    // Scan engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : ones_pkg
`default_nettype wire

// File: rtl/ones_pattern_gen_popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount_w
// Description : Combinational ones counter for a WIDTH-bit candidate word.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]               cand,
    output logic [$clog2(WIDTH+1)-1:0]     count
);

    localparam int c_KW = $clog2(WIDTH + 1);

    // Sum every bit of the candidate into a KW-bit count
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + c_KW'(cand[i]);
        end
    end

endmodule : popcount_w
`default_nettype wire

// File: rtl/ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : ones_pattern_gen
// Description : Emits every WIDTH-bit word with popcount K in ascending order
//               over a valid/ready stream, by scanning all candidates.
// Revision    : 1.0 - initial release
// ============================================================================
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(WIDTH+1)-1:0]    k,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [WIDTH-1:0]              out_index,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              total,
    output logic                          err
);

    localparam int               c_KW       = $clog2(WIDTH + 1);
    localparam logic [c_KW-1:0]  c_MAX_K    = c_KW'(WIDTH);
    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

    state_t            r_state;
    logic [c_KW-1:0]   r_k;
    logic [WIDTH-1:0]  r_cand;
    logic [c_KW-1:0]   w_count;
    logic              w_last;

    popcount_w #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .cand  (r_cand),
        .count (w_count)
    );

    // The run ends at the all-ones candidate; cand never wraps
    assign w_last = (r_cand == c_ALL_ONES);

    // Scan FSM: walk candidates, present matches, count handshakes into total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_cand    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            total     <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (k > c_MAX_K) begin
                            err <= 1'b1;
                        end else begin
                            r_k       <= k;
                            r_cand    <= '0;
                            out_index <= '0;
                            busy      <= 1'b1;
                            r_state   <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_count == r_k) begin
                        out_data  <= r_cand;
                        out_valid <= 1'b1;
                        r_state   <= HOLD;
                    end else if (w_last) begin
                        // out_index already equals the number of handshakes
                        total   <= out_index;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_index <= out_index + 1'b1;
                        if (w_last) begin
                            total   <= out_index + 1'b1;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cand  <= r_cand + 1'b1;
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : ones_pattern_gen
`default_nettype wire

// File: tb/tb_ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_pattern_gen
// Description : Scoreboard bench for ones_pattern_gen (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_pattern_gen;

    localparam int c_W  = 8;
    localparam int c_KW = $clog2(c_W + 1);

    logic              clk;
    logic              rst;
    logic              start;
    logic [c_KW-1:0]   k;
    logic              out_ready;
    logic              out_valid;
    logic [c_W-1:0]    out_data;
    logic [c_W-1:0]    out_index;
    logic              busy;
    logic              done;
    logic [c_W-1:0]    total;
    logic              err;

    int n_total;
    int n_bad;
    logic [c_W-1:0] exp_q[$];

    ones_pattern_gen #(
        .WIDTH (c_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done),
        .total     (total),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Fill the scoreboard with every 8-bit word whose popcount is kk
    task automatic load_model(input int kk);
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            if ($countones(v) == kk) exp_q.push_back(c_W'(v));
        end
    endtask

    // mode 0: ready always high; 1: random ready + stray start; 2: 5-cycle stall on first word
    task automatic run(input int kk, input int mode);
        int  idx;
        int  n_exp;
        bit  got_done;
        bit  seen;
        load_model(kk);
        n_exp = exp_q.size();
        @(negedge clk);
        k         = c_KW'(kk);
        start     = 1'b1;
        out_ready = (mode == 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mode == 2) begin
            seen = 1'b0;
            for (int c = 0; c < 50; c++) begin
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_val("stall_wait_valid", 32'(seen), 32'd1);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check_val("stall_valid", 32'(out_valid), 32'd1);
                check_val("stall_data", 32'(out_data), 32'(exp_q[0]));
                check_val("stall_index", 32'(out_index), 32'd0);
            end
        end
        idx      = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done) begin
                check_val("done_busy", 32'(busy), 32'd1);
                check_val("total", 32'(total), 32'(n_exp));
                got_done = 1'b1;
                break;
            end
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (mode == 1 && cyc == 20);
            k         = (mode == 1 && cyc == 20) ? c_KW'(1) : c_KW'(kk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check_val("data", 32'(out_data), 32'(exp_q.pop_front()));
                    check_val("index", 32'(out_index), 32'(idx));
                end
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("run_finished", 32'(got_done), 32'd1);
        check_val("words_left", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        k         = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_index", 32'(out_index), 32'd0);
        check_val("rst_total", 32'(total), 32'd0);
        check_val("rst_flags", {29'd0, busy, done, err}, 32'd0);
        rst = 1'b0;

        run(0, 0);
        run(1, 0);
        run(4, 1);
        run(8, 0);

        // Out-of-range k: error pulse only
        @(negedge clk);
        k     = c_KW'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("k9_err", 32'(err), 32'd1);
        check_val("k9_valid", 32'(out_valid), 32'd0);
        check_val("k9_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("k9_err_pulse", 32'(err), 32'd0);
        check_val("k9_busy2", 32'(busy), 32'd0);

        run(2, 2);

        // Reset in the middle of a k=3 run when 0x0B is on the output
        begin
            bit hit;
            hit = 1'b0;
            @(negedge clk);
            k         = c_KW'(3);
            start     = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (out_valid && out_data == 8'h0B) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_val("rst_mid_reach_0B", 32'(hit), 32'd1);
            rst = 1'b1;
            #1;
            check_val("rst_mid_valid", 32'(out_valid), 32'd0);
            check_val("rst_mid_data", 32'(out_data), 32'd0);
            check_val("rst_mid_index", 32'(out_index), 32'd0);
            check_val("rst_mid_flags", {29'd0, busy, done, err}, 32'd0);
            @(negedge clk);
            rst       = 1'b0;
            out_ready = 1'b0;
        end
        run(3, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ones_pattern_gen
`default_nettype wire
